// File: rtl/mips_pkg.sv
// Shared definitions for the mips_core boot path: loader state encoding,
// word geometry and the default instruction-memory address width.
package mips_pkg;

    localparam int IMEM_ADDR_W    = 8;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] LD_IDLE   = 3'd0;
    localparam logic [2:0] LD_HDR_HI = 3'd1;
    localparam logic [2:0] LD_HDR_LO = 3'd2;
    localparam logic [2:0] LD_DATA   = 3'd3;
    localparam logic [2:0] LD_WRITE  = 3'd4;
    localparam logic [2:0] LD_CHK    = 3'd5;
    localparam logic [2:0] LD_DONE   = 3'd6;
    localparam logic [2:0] LD_ERROR  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = LD_IDLE,
        ST_HDR_HI = LD_HDR_HI,
        ST_HDR_LO = LD_HDR_LO,
        ST_DATA   = LD_DATA,
        ST_WRITE  = LD_WRITE,
        ST_CHK    = LD_CHK,
        ST_DONE   = LD_DONE,
        ST_ERROR  = LD_ERROR
    } ld_state_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word assembler: shifts accepted bytes in MSB-first and
// presents the complete word combinationally alongside its 4th byte.
module imem_word_assembler
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    // Only the three most recent bytes are kept; the 4th joins them on the way out.
    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clr_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_valid_i) begin
            shift_q <= {shift_q[15:0], byte_i};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory boot loader: parses a count-prefixed byte frame, writes
// words from address 0 and holds mips_core in reset until the load completes.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W         = IMEM_ADDR_W,
    parameter bit START_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    ld_state_e         state_q;
    logic [7:0]        cnt_hi_q;
    logic [15:0]       cnt_q;
    logic [16:0]       idx_q;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              core_rst_q;
    logic              done_q;
    logic              err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        chk_q;
`endif

    logic        accept;
    logic [15:0] cnt_d;
    logic [16:0] idx_d;
    logic [31:0] asm_word;
    logic        asm_word_valid;

    assign accept = in_valid && in_ready_q;
    assign cnt_d  = {cnt_hi_q, in_data};
    assign idx_d  = idx_q + 17'd1;

    imem_word_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst),
        .clr_i        (state_q != ST_DATA && state_q != ST_WRITE),
        .byte_valid_i (accept && state_q == ST_DATA),
        .byte_i       (in_data),
        .word_o       (asm_word),
        .word_valid_o (asm_word_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_hi_q    <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept && state_q != ST_CHK) begin
                chk_q <= chk_q ^ in_data;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (START_ON_RESET || start) begin
                        state_q    <= ST_HDR_HI;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_HDR_HI: begin
                    if (accept) begin
                        cnt_hi_q <= in_data;
                        state_q  <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (accept) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_q <= ST_CHK;
`else
                            state_q    <= ST_DONE;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
`endif
                        end else if ({1'b0, cnt_d} > DEPTH) begin
                            state_q    <= ST_ERROR;
                            in_ready_q <= 1'b0;
                            err_q      <= 1'b1;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept && asm_word_valid) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= idx_q[ADDR_W-1:0];
                        mem_wdata_q <= asm_word;
                        state_q     <= ST_WRITE;
                        in_ready_q  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    // Index may reach DEPTH here; it is never used as an address again.
                    idx_q <= idx_d;
                    if (idx_d == {1'b0, cnt_q}) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q    <= ST_CHK;
                        in_ready_q <= 1'b1;
`else
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        core_rst_q <= 1'b0;
`endif
                    end else begin
                        state_q    <= ST_DATA;
                        in_ready_q <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (in_data == chk_q) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                        end else begin
                            state_q <= ST_ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_q    <= ST_HDR_HI;
                        in_ready_q <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        core_rst_q <= 1'b1;
                        idx_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_q      <= '0;
`endif
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_rst  = core_rst_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table, random frames and
// hand-written corner sequences checked against a frame-level reference model.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .START_ON_RESET(1'b1)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/status monitor
    logic [ADDR_W-1:0] obs_addr [4096];
    logic [31:0]       obs_data [4096];
    int                n_we = 0;
    int                last_we_cyc = 0;
    int                done_rise_cyc = 0;
    logic              done_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_we && n_we < 4096) begin
            obs_addr[n_we] = mem_addr;
            obs_data[n_we] = mem_wdata;
            n_we = n_we + 1;
            last_we_cyc = cyc;
        end
        if (done && !done_prev) done_rise_cyc = cyc;
        done_prev = done;
    end

    logic [31:0] cur_words [$];
    logic [7:0]  tx_bytes [$];

    typedef struct {
        logic [15:0] n;
        int          gap_max;
        int          stall_idx;
        int          stall_len;
        bit          poke_start;
        bit          bad_chk;
        bit          exp_ok;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_words(input logic [15:0] n);
        cur_words.delete();
        if (n <= DEPTH) begin
            for (int i = 0; i < int'(n); i++) cur_words.push_back($urandom);
        end
    endtask

    // Model of the frame encoding: header, big-endian words, optional XOR byte.
    task automatic build_frame(input logic [15:0] n, input bit bad_chk);
        logic [7:0] x;
        tx_bytes.delete();
        tx_bytes.push_back(n[15:8]);
        tx_bytes.push_back(n[7:0]);
        foreach (cur_words[i]) begin
            for (int b = 3; b >= 0; b--) tx_bytes.push_back(8'(cur_words[i] >> (8 * b)));
        end
        x = 8'h00;
        foreach (tx_bytes[i]) x = x ^ tx_bytes[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (n <= DEPTH) tx_bytes.push_back(bad_chk ? (x ^ 8'h5A) : x);
`else
        if (bad_chk) x = ~x;
`endif
    endtask

    task automatic send_bytes(input int nbytes, input int gap_max, input int stall_idx,
                              input int stall_len, input bit poke_start);
        for (int i = 0; i < nbytes && i < tx_bytes.size(); i++) begin
            int gap;
            bit acc;
            int w;
            gap = (i == stall_idx) ? stall_len : int'($urandom_range(gap_max, 0));
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                if (poke_start && i == stall_idx && g == 1) start = 1'b1;
                tick();
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = tx_bytes[i];
            acc = 1'b0;
            w = 0;
            while (!acc && w < 40) begin
                acc = in_ready;
                tick();
                w++;
            end
            if (!acc) begin
                check("byte_accept_timeout", 64'(i), 64'hFFFF);
                in_valid = 1'b0;
                return;
            end
            last_acc_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] n, input int gap_max, input int stall_idx,
                             input int stall_len, input bit poke_start, input bit bad_chk,
                             input bit exp_ok);
        int base;
        int exp_nw;
        int got_nw;
        base = n_we;
        build_frame(n, bad_chk);
        send_bytes(tx_bytes.size(), gap_max, stall_idx, stall_len, poke_start);
        for (int w = 0; w < 40 && !(done || err); w++) tick();
        tick();
        exp_nw = (n <= DEPTH) ? int'(n) : 0;
        got_nw = n_we - base;
        check("done", 64'(done), 64'(exp_ok));
        check("err", 64'(err), 64'(!exp_ok));
        check("core_rst", 64'(core_rst), 64'(!exp_ok));
        check("in_ready_idle", 64'(in_ready), 64'd0);
        check("write_count", 64'(got_nw), 64'(exp_nw));
        for (int i = 0; i < exp_nw && i < got_nw; i++) begin
            check("write_addr", 64'(obs_addr[base + i]), 64'(i % DEPTH));
            check("write_data", 64'(obs_data[base + i]), 64'(cur_words[i]));
        end
        if (exp_ok) begin
            check("done_latency_le3", 64'((done_rise_cyc - last_acc_cyc) <= 3), 64'd1);
`ifndef IMEM_LOADER_CHECKSUM_EN
            if (n != 16'd0) begin
                check("write_after_4th_byte", 64'(last_we_cyc - last_acc_cyc), 64'd0);
                check("done_after_last_write", 64'(done_rise_cyc - last_we_cyc), 64'd1);
            end
`endif
        end
        $display("frame n=%0d bytes=%0d writes=%0d done=%b err=%b core_rst=%b",
                 n, tx_bytes.size(), got_nw, done, err, core_rst);
    endtask

    task automatic restart();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_core_rst", 64'(core_rst), 64'd1);
        check("restart_done", 64'(done), 64'd0);
        check("restart_err", 64'(err), 64'd0);
        check("restart_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        vecs.push_back('{n: 16'd0,     gap_max: 0, stall_idx: -1, stall_len: 0, poke_start: 0, bad_chk: 0, exp_ok: 1});
        vecs.push_back('{n: 16'd257,   gap_max: 1, stall_idx: -1, stall_len: 0, poke_start: 0, bad_chk: 0, exp_ok: 0});
        vecs.push_back('{n: 16'd1,     gap_max: 2, stall_idx: -1, stall_len: 0, poke_start: 0, bad_chk: 0, exp_ok: 1});
        vecs.push_back('{n: 16'd4,     gap_max: 0, stall_idx: 4,  stall_len: 7, poke_start: 1, bad_chk: 0, exp_ok: 1});
        vecs.push_back('{n: 16'd256,   gap_max: 0, stall_idx: -1, stall_len: 0, poke_start: 0, bad_chk: 0, exp_ok: 1});
        vecs.push_back('{n: 16'hFFFF,  gap_max: 0, stall_idx: -1, stall_len: 0, poke_start: 0, bad_chk: 0, exp_ok: 0});
        vecs.push_back('{n: 16'd6,     gap_max: 3, stall_idx: 9,  stall_len: 7, poke_start: 0, bad_chk: 0, exp_ok: 1});
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back('{n: 16'd2,     gap_max: 1, stall_idx: -1, stall_len: 0, poke_start: 0, bad_chk: 1, exp_ok: 0});
`endif

        // Reset values
        repeat (3) tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_core_rst", 64'(core_rst), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        tick();
        check("armed_after_reset", 64'(in_ready), 64'd1);

        // Reference program from the bring-up test
        cur_words.delete();
        cur_words.push_back(32'h20080005);
        cur_words.push_back(32'h20090005);
        cur_words.push_back(32'h11090001);
        run_frame(16'd3, 0, -1, 0, 1'b0, 1'b0, 1'b1);

        foreach (vecs[k]) begin
            restart();
            fill_words(vecs[k].n);
            run_frame(vecs[k].n, vecs[k].gap_max, vecs[k].stall_idx, vecs[k].stall_len,
                      vecs[k].poke_start, vecs[k].bad_chk, vecs[k].exp_ok);
        end

        // Asynchronous reset between the 2nd and 3rd word, then a fresh frame
        begin
            int base;
            restart();
            fill_words(16'd3);
            build_frame(16'd3, 1'b0);
            base = n_we;
            send_bytes(10, 0, -1, 0, 1'b0);
            repeat (2) tick();
            check("midload_writes", 64'(n_we - base), 64'd2);
            #2 rst_n = 1'b0;
            #1;
            check("async_core_rst", 64'(core_rst), 64'd1);
            check("async_in_ready", 64'(in_ready), 64'd0);
            check("async_mem_we", 64'(mem_we), 64'd0);
            check("async_done", 64'(done), 64'd0);
            check("async_mem_addr", 64'(mem_addr), 64'd0);
            repeat (2) tick();
            rst_n = 1'b1;
            tick();
            cur_words.delete();
            cur_words.push_back(32'hDEADBEEF);
            run_frame(16'd1, 1, -1, 0, 1'b0, 1'b0, 1'b1);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        restart();
        cur_words.delete();
        cur_words.push_back(32'h12345678);
        run_frame(16'd1, 0, -1, 0, 1'b0, 1'b0, 1'b1);
        restart();
        run_frame(16'd1, 0, -1, 0, 1'b0, 1'b1, 1'b0);
`endif

        // Randomised frames
        for (int r = 0; r < 6; r++) begin
            logic [15:0] n;
            n = ($urandom_range(3, 0) == 0) ? 16'($urandom_range(1000, 257))
                                            : 16'($urandom_range(40, 0));
            restart();
            fill_words(n);
            run_frame(n, int'($urandom_range(2, 0)), -1, 0, 1'b0, 1'b0, n <= DEPTH);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
